// File: rtl/exec_unit_mc_if.sv
// Issue/result bundle for exec_unit_mc: issue side driven by the issuer (master),
// result side driven by the execute unit (slave).
interface exec_unit_mc_if #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 14,
  parameter int ADDR_W = 6,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   pc;
  logic [5:0]        ope;
  logic [XLEN-1:0]   ds_val;
  logic [XLEN-1:0]   dt_val;
  logic [ADDR_W-1:0] dd;
  logic [IMM_W-1:0]  imm;
  logic [4:0]        opr;
  logic              busy;
  logic              b_taken;
  logic [PC_W-1:0]   b_addr;
  logic [ADDR_W-1:0] alu_addr;
  logic [XLEN-1:0]   alu_dd_val;

  modport master (
    output in_valid, pc, ope, ds_val, dt_val, dd, imm, opr,
    input  in_ready, busy, b_taken, b_addr, alu_addr, alu_dd_val
  );

  modport slave (
    input  in_valid, pc, ope, ds_val, dt_val, dd, imm, opr,
    output in_ready, busy, b_taken, b_addr, alu_addr, alu_dd_val
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Integer execute unit: branch resolve, single-cycle ALU/shift/link ops and an
// iterative radix-2 multiply that is only built when EXEC_MUL_EN is defined.
module exec_unit_mc #(
  parameter int XLEN     = 32,
  parameter int PC_W     = 14,
  parameter int ADDR_W   = 6,
  parameter int IMM_W    = 16,
  parameter int LINK_REG = 31
) (
  input logic           clk,
  input logic           rst,
  exec_unit_mc_if.slave bus
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADD  = 6'b001100;
  localparam logic [5:0] OP_SUB  = 6'b010100;
  localparam logic [5:0] OP_SLLI = 6'b011000;
  localparam logic [5:0] OP_SLL  = 6'b011100;
  localparam logic [5:0] OP_SRLI = 6'b100000;
  localparam logic [5:0] OP_SRL  = 6'b100100;
  localparam logic [5:0] OP_SRAI = 6'b101000;
  localparam logic [5:0] OP_SRA  = 6'b101100;
  localparam logic [5:0] OP_LUI  = 6'b110000;
  localparam logic [5:0] OP_JAL  = 6'b000110;
  localparam logic [5:0] OP_JALR = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b010010;
  localparam logic [5:0] OP_BLE  = 6'b011010;
  localparam logic [5:0] OP_BEQI = 6'b110010;
  localparam logic [5:0] OP_BNEI = 6'b111010;
  localparam logic [5:0] OP_BLEI = 6'b100010;
  localparam logic [5:0] OP_BGEI = 6'b101010;

  logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
  logic [XLEN-1:0]   alu_dd_val_q, alu_dd_val_d;
  logic              b_taken_q, b_taken_d;
  logic [PC_W-1:0]   b_addr_q, b_addr_d;

  logic [XLEN-1:0]   imm_ext, opr_ext, op_a, op_b;
  logic [SH_W-1:0]   shamt;
  logic [PC_W-1:0]   pc_inc;
  logic [ADDR_W-1:0] res_addr;
  logic [XLEN-1:0]   res_val;
  logic              res_taken;

  assign imm_ext = {{(XLEN-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign opr_ext = {{(XLEN-5){bus.opr[4]}}, bus.opr};
  assign op_a    = bus.ds_val;
  assign op_b    = bus.ope[2] ? bus.dt_val : imm_ext;
  assign shamt   = op_b[SH_W-1:0];
  assign pc_inc  = bus.pc + PC_W'(1);

  // Single-cycle decode; non-writing ops leave the writeback value unchanged.
  always_comb begin
    res_addr  = '0;
    res_val   = alu_dd_val_q;
    res_taken = 1'b0;
    case (bus.ope)
      OP_ADD, OP_ADDI: begin
        res_addr = bus.dd;
        res_val  = op_a + op_b;
      end
      OP_SUB: begin
        res_addr = bus.dd;
        res_val  = op_a - op_b;
      end
      OP_SLL, OP_SLLI: begin
        res_addr = bus.dd;
        res_val  = op_a << shamt;
      end
      OP_SRL, OP_SRLI: begin
        res_addr = bus.dd;
        res_val  = op_a >> shamt;
      end
      OP_SRA, OP_SRAI: begin
        res_addr = bus.dd;
        res_val  = $signed(op_a) >>> shamt;
      end
      OP_LUI: begin
        res_addr = bus.dd;
        res_val  = {bus.imm, bus.ds_val[XLEN-IMM_W-1:0]};
      end
      OP_JAL, OP_JALR: begin
        res_addr = LINK_ADDR;
        res_val  = {{(XLEN-PC_W){1'b0}}, pc_inc};
      end
      OP_BEQ:  res_taken = (bus.ds_val == bus.dt_val);
      OP_BLE:  res_taken = ($signed(bus.ds_val) <= $signed(bus.dt_val));
      OP_BEQI: res_taken = (bus.ds_val == opr_ext);
      OP_BNEI: res_taken = (bus.ds_val != opr_ext);
      OP_BLEI: res_taken = ($signed(bus.ds_val) <= $signed(opr_ext));
      OP_BGEI: res_taken = ($signed(bus.ds_val) >= $signed(opr_ext));
      default: res_taken = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [5:0]      OP_MUL   = 6'b111100;
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(XLEN - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [ADDR_W-1:0] mul_dd_q, mul_dd_d;
  logic [XLEN-1:0]   acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and output update; the last step's sum goes straight to writeback.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    mul_dd_d     = mul_dd_q;
    alu_addr_d   = '0;
    alu_dd_val_d = alu_dd_val_q;
    b_taken_d    = 1'b0;
    b_addr_d     = b_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          b_addr_d = bus.imm[PC_W-1:0];
          if (bus.ope == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = bus.ds_val;
            mplier_d = bus.dt_val;
            mul_dd_d = bus.dd;
          end else begin
            alu_addr_d   = res_addr;
            alu_dd_val_d = res_val;
            b_taken_d    = res_taken;
          end
        end else begin
          b_taken_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          alu_addr_d   = mul_dd_q;
          alu_dd_val_d = acc_sum;
        end else begin
          cnt_d = cnt_q + SH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiply state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_dd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mul_dd_q <= mul_dd_d;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_MUL);
`else
  // Every op completes in one cycle, so the unit never stalls.
  always_comb begin
    alu_addr_d   = '0;
    alu_dd_val_d = alu_dd_val_q;
    b_taken_d    = 1'b0;
    b_addr_d     = b_addr_q;
    if (bus.in_valid) begin
      alu_addr_d   = res_addr;
      alu_dd_val_d = res_val;
      b_taken_d    = res_taken;
      b_addr_d     = bus.imm[PC_W-1:0];
    end else begin
      b_taken_d = 1'b0;
    end
  end

  assign bus.in_ready = 1'b1;
  assign bus.busy     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_addr_q   <= '0;
      alu_dd_val_q <= '0;
      b_taken_q    <= 1'b0;
      b_addr_q     <= '0;
    end else begin
      alu_addr_q   <= alu_addr_d;
      alu_dd_val_q <= alu_dd_val_d;
      b_taken_q    <= b_taken_d;
      b_addr_q     <= b_addr_d;
    end
  end

  assign bus.alu_addr   = alu_addr_q;
  assign bus.alu_dd_val = alu_dd_val_q;
  assign bus.b_taken    = b_taken_q;
  assign bus.b_addr     = b_addr_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Scoreboard bench for exec_unit_mc: the driver queues expected results tagged with
// the edge they must appear at; a negedge monitor compares them.
module tb_exec_unit_mc;

  localparam int XLEN = 32;

  typedef struct {
    int          due;
    logic [5:0]  addr;
    logic [31:0] val;
    bit          chk_val;
    logic        taken;
    logic [13:0] baddr;
    bit          chk_b;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  exec_unit_mc_if bus ();

  exec_unit_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare a queued expectation at its edge, otherwise nothing may be written.
  always @(negedge clk) begin
    exp_t e;
    if (edge_cnt > 0) begin
      if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
        e = exp_q.pop_front();
        checks++;
        if (e.due != edge_cnt || bus.alu_addr !== e.addr || bus.b_taken !== e.taken ||
            (e.chk_val && bus.alu_dd_val !== e.val) || (e.chk_b && bus.b_addr !== e.baddr)) begin
          errors++;
          $display("FAIL %s @edge %0d: got addr=%0d val=%h taken=%0d baddr=%h, expected addr=%0d val=%h taken=%0d baddr=%h (due %0d)",
                   e.name, edge_cnt, bus.alu_addr, bus.alu_dd_val, bus.b_taken, bus.b_addr,
                   e.addr, e.val, e.taken, e.baddr, e.due);
        end
      end else begin
        checks++;
        if (bus.alu_addr !== 6'd0 || bus.b_taken !== 1'b0) begin
          errors++;
          $display("FAIL idle @edge %0d: got addr=%0d taken=%0d, expected addr=0 taken=0",
                   edge_cnt, bus.alu_addr, bus.b_taken);
        end
      end
    end
  end

  task automatic push(input int due, input logic [5:0] a, input logic [31:0] v, input bit cv,
                      input logic t, input logic [13:0] ba, input bit cb, input string nm);
    exp_t e;
    e.due = due; e.addr = a; e.val = v; e.chk_val = cv;
    e.taken = t; e.baddr = ba; e.chk_b = cb; e.name = nm;
    exp_q.push_back(e);
  endtask

  // lat = 0 drives the op without queueing a result
  task automatic issue(input logic [5:0] op, input logic [31:0] ds, input logic [31:0] dt,
                       input logic [5:0] dd, input logic [15:0] imm, input logic [4:0] opr,
                       input logic [13:0] pc, input logic [5:0] e_addr, input logic [31:0] e_val,
                       input bit cv, input logic e_taken, input int lat, input string nm);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ope = op; bus.ds_val = ds; bus.dt_val = dt; bus.dd = dd;
    bus.imm = imm; bus.opr = opr; bus.pc = pc;
    if (lat > 0) push(edge_cnt + lat, e_addr, e_val, cv, e_taken, imm[13:0], 1'b1, nm);
  endtask

  task automatic hold_chk(input logic [31:0] v, input logic [13:0] ba, input string nm);
    @(negedge clk);
    bus.in_valid = 1'b0;
    push(edge_cnt + 1, 6'd0, v, 1'b1, 1'b0, ba, 1'b1, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic chk_rb(input logic e_busy, input logic e_ready, input string nm);
    checks++;
    if (bus.busy !== e_busy || bus.in_ready !== e_ready) begin
      errors++;
      $display("FAIL %s @edge %0d: got busy=%0d in_ready=%0d, expected busy=%0d in_ready=%0d",
               nm, edge_cnt, bus.busy, bus.in_ready, e_busy, e_ready);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.ope      = 6'($urandom);
    bus.ds_val   = $urandom;
    bus.dt_val   = $urandom;
    bus.dd       = 6'($urandom);
    bus.imm      = 16'($urandom);
    bus.opr      = 5'($urandom);
    bus.pc       = 14'($urandom);
    push(1, 6'd0, 32'd0, 1'b1, 1'b0, 14'd0, 1'b1, "reset1");
    push(2, 6'd0, 32'd0, 1'b1, 1'b0, 14'd0, 1'b1, "reset2");
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk_rb(1'b0, 1'b1, "reset_ready");

    issue(6'b001000, 32'd5, 32'd0, 6'd3, 16'hFFFF, 5'd0, 14'd0, 6'd3, 32'd4, 1'b1, 1'b0, 1, "addi");
    hold_chk(32'd4, 14'h3FFF, "hold");
    issue(6'b001100, 32'h7FFFFFFF, 32'd1, 6'd5, 16'h0000, 5'd0, 14'd0, 6'd5, 32'h80000000, 1'b1, 1'b0, 1, "add_wrap");
    issue(6'b010100, 32'd0, 32'd1, 6'd6, 16'h0000, 5'd0, 14'd0, 6'd6, 32'hFFFFFFFF, 1'b1, 1'b0, 1, "sub");
    issue(6'b101100, 32'h80000000, 32'd33, 6'd7, 16'h0000, 5'd0, 14'd0, 6'd7, 32'hC0000000, 1'b1, 1'b0, 1, "sra");
    issue(6'b100100, 32'h80000000, 32'd33, 6'd8, 16'h0000, 5'd0, 14'd0, 6'd8, 32'h40000000, 1'b1, 1'b0, 1, "srl");
    issue(6'b011000, 32'd1, 32'd0, 6'd2, 16'h001F, 5'd0, 14'd0, 6'd2, 32'h80000000, 1'b1, 1'b0, 1, "slli");
    issue(6'b101000, 32'hF0000000, 32'd0, 6'd4, 16'h0004, 5'd0, 14'd0, 6'd4, 32'hFF000000, 1'b1, 1'b0, 1, "srai");
    issue(6'b110000, 32'h12345678, 32'd0, 6'd10, 16'hABCD, 5'd0, 14'd0, 6'd10, 32'hABCD5678, 1'b1, 1'b0, 1, "lui");
    issue(6'b000110, 32'd0, 32'd0, 6'd12, 16'h0000, 5'd0, 14'h3FFF, 6'd31, 32'd0, 1'b1, 1'b0, 1, "jal_wrap");
    issue(6'b001110, 32'd0, 32'd0, 6'd12, 16'h0000, 5'd0, 14'h0123, 6'd31, 32'h00000124, 1'b1, 1'b0, 1, "jalr");
    issue(6'b100010, 32'hFFFFFFFD, 32'd0, 6'd1, 16'h0040, 5'b11101, 14'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1, "blei");
    issue(6'b111010, 32'hFFFFFFFD, 32'd0, 6'd1, 16'h0040, 5'b11101, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1, "bnei");
    issue(6'b010010, 32'h55, 32'h55, 6'd1, 16'h0100, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1, "beq");
    issue(6'b011010, 32'hFFFFFFFF, 32'd0, 6'd1, 16'h0200, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1, "ble_signed");
    issue(6'b101010, 32'd2, 32'd0, 6'd1, 16'h0300, 5'b00011, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1, "bgei");
    issue(6'b110010, 32'hFFFFFFF0, 32'd0, 6'd1, 16'h0400, 5'b10000, 14'd0, 6'd0, 32'd0, 1'b0, 1'b1, 1, "beqi");
    issue(6'b000010, 32'd0, 32'd0, 6'd5, 16'h0500, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1, "j");
    issue(6'b111111, 32'd1, 32'd1, 6'd5, 16'h0600, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1, "undef");
    idle(2);

`ifdef EXEC_MUL_EN
    issue(6'b111100, 32'd7, 32'hFFFFFFFE, 6'd9, 16'h0021, 5'd0, 14'd0, 6'd9, 32'hFFFFFFF2, 1'b1, 1'b0, XLEN + 1, "mul");
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk);
      chk_rb(1'b1, 1'b0, "mul_busy");
      if (i < 3) begin
        bus.in_valid = 1'b1;
        bus.ope      = 6'b001000;
        bus.dd       = 6'd1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    issue(6'b111100, 32'd5, 32'd3, 6'd0, 16'h0022, 5'd0, 14'd0, 6'd0, 32'd15, 1'b1, 1'b0, XLEN + 1, "mul_b2b_dd0");
    chk_rb(1'b0, 1'b1, "mul_done_ready");
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk);
      chk_rb(1'b1, 1'b0, "mul2_busy");
      bus.in_valid = 1'b0;
    end
    issue(6'b111100, 32'd3, 32'd3, 6'd11, 16'h0023, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 0, "mul_abort");
    idle(10);
    @(negedge clk);
    rst = 1'b1;
    push(edge_cnt + 1, 6'd0, 32'd0, 1'b1, 1'b0, 14'd0, 1'b1, "abort_reset");
    @(negedge clk);
    rst = 1'b0;
    chk_rb(1'b0, 1'b1, "abort_idle");
    idle(XLEN + 8);
`else
    issue(6'b111100, 32'd7, 32'd2, 6'd9, 16'h0700, 5'd0, 14'd0, 6'd0, 32'd0, 1'b0, 1'b0, 1, "mul_undef");
    issue(6'b001000, 32'd1, 32'd0, 6'd2, 16'h0001, 5'd0, 14'd0, 6'd2, 32'd2, 1'b1, 1'b0, 1, "no_stall");
    chk_rb(1'b0, 1'b1, "mul_undef_ready");
    idle(2);
`endif

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
